corelet_seq: RTL

Instruction sequencer that sits directly upstream of the corelet and drives its 35-bit instruction bus for one full tile pass. It runs the pass in this order: kernel fetch from activation/weight SRAM into L0, kernel load into the MAC array, activation fetch, execute, then OFIFO drain.
Single FSM with down-counters. It is the only writer of corelet inst[34:0] and the SRAM read port during a pass.

---
 rtl/corelet_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/corelet_seq.sv
// Tile-pass instruction sequencer for the corelet: kernel fetch/load, activation fetch, execute, drain.
// Optional: define SEQ_AUTO_ACC_EN to emit an accumulate pulse (inst[33]) one cycle after each OFIFO read.
module corelet_seq #(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned addr_bw  = 11,
    parameter int unsigned len_bw   = 8,
    parameter int unsigned l0_depth = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] kernel_base,
    input  logic [addr_bw-1:0] act_base,
    input  logic [len_bw-1:0]  num_act,
    input  logic               ofifo_valid,
    output logic [34:0]        inst,
    output logic               sram_cen,
    output logic [addr_bw-1:0] sram_addr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    if (row == 0 || col == 0 || col > (1 << len_bw)) begin : g_bad_param
        $error("corelet_seq: row/col out of range");
    end

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] K_FILL   = 4'd1;
    localparam logic [3:0] K_WAIT   = 4'd2;
    localparam logic [3:0] K_LOAD   = 4'd3;
    localparam logic [3:0] K_SETTLE = 4'd4;
    localparam logic [3:0] A_FILL   = 4'd5;
    localparam logic [3:0] A_WAIT   = 4'd6;
    localparam logic [3:0] EXEC     = 4'd7;
    localparam logic [3:0] DRAIN    = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    localparam logic [len_bw-1:0] COL_LAST = len_bw'(col - 1);
    localparam logic [len_bw:0]   ACT_MAX  = (len_bw + 1)'(l0_depth);

    logic [3:0]         state_q, state_d;
    logic [len_bw-1:0]  cnt_q, cnt_d;
    logic [addr_bw-1:0] act_base_q, act_base_d;
    logic [len_bw-1:0]  num_q, num_d;
    logic               err_q, err_d;
    logic               sram_cen_q, sram_cen_d;
    logic [addr_bw-1:0] sram_addr_q, sram_addr_d;
    logic               l0_wr_q, l0_rd_q, busy_q, done_q;
    logic [1:0]         inst_w_q;
    logic               ofifo_rd, acc;

    // The OFIFO read must track ofifo_valid in the same cycle, so it is gated, not registered.
    assign ofifo_rd = (state_q == DRAIN) && ofifo_valid && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_base_d  = act_base_q;
        num_d       = num_q;
        err_d       = err_q;
        sram_cen_d  = 1'b1;
        sram_addr_d = sram_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_act == '0 || {1'b0, num_act} > ACT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        act_base_d  = act_base;
                        num_d       = num_act;
                        state_d     = K_FILL;
                        cnt_d       = COL_LAST;
                        sram_cen_d  = 1'b0;
                        sram_addr_d = kernel_base;
                    end
                end
            end
            K_FILL: begin
                if (cnt_q == '0) begin
                    state_d = K_WAIT;
                end else begin
                    cnt_d       = cnt_q - 1'b1;
                    sram_cen_d  = 1'b0;
                    sram_addr_d = sram_addr_q + 1'b1;
                end
            end
            K_WAIT: begin
                state_d = K_LOAD;
                cnt_d   = COL_LAST;
            end
            K_LOAD: begin
                if (cnt_q == '0) begin
                    state_d = K_SETTLE;
                    cnt_d   = COL_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            K_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = A_FILL;
                    cnt_d       = num_q - 1'b1;
                    sram_cen_d  = 1'b0;
                    sram_addr_d = act_base_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            A_FILL: begin
                if (cnt_q == '0) begin
                    state_d = A_WAIT;
                end else begin
                    cnt_d       = cnt_q - 1'b1;
                    sram_cen_d  = 1'b0;
                    sram_addr_d = sram_addr_q + 1'b1;
                end
            end
            A_WAIT: begin
                state_d = EXEC;
                cnt_d   = num_q - 1'b1;
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                    cnt_d   = num_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // cnt counts reads still owed to the OFIFO.
            DRAIN: begin
                if (ofifo_rd) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == len_bw'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            act_base_q  <= '0;
            num_q       <= '0;
            err_q       <= 1'b0;
            sram_cen_q  <= 1'b1;
            sram_addr_q <= '0;
            l0_wr_q     <= 1'b0;
            l0_rd_q     <= 1'b0;
            inst_w_q    <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_base_q  <= act_base_d;
            num_q       <= num_d;
            err_q       <= err_d;
            sram_cen_q  <= sram_cen_d;
            sram_addr_q <= sram_addr_d;
            l0_wr_q     <= ~sram_cen_q;
            l0_rd_q     <= (state_d == K_LOAD) || (state_d == EXEC);
            inst_w_q    <= (state_d == K_LOAD) ? 2'b01 : (state_d == EXEC) ? 2'b10 : 2'b00;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

`ifdef SEQ_AUTO_ACC_EN
    logic acc_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= 1'b0;
        else        acc_q <= ofifo_rd;
    end
    assign acc = acc_q;
`else
    assign acc = 1'b0;
`endif

    assign inst = {1'b0, acc, 26'b0, ofifo_rd, 2'b00, l0_rd_q, l0_wr_q, inst_w_q};
    assign sram_cen  = sram_cen_q;
    assign sram_addr = sram_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
